window_mac: RTL and testbench

Downstream consumer of the img2col processing-unit controller. Each 25-element (5x5) window vector it produces is multiplied element-wise by 25 stationary kernel weights, reduced through a pipelined adder tree, and accumulated across input channels. A signed result is emitted under a valid/ready handshake when the last channel of an output pixel retires. Weights are loaded serially before windows are accepted.

---
 rtl/window_mac_if.sv | 28 ++
 rtl/window_mac.sv | 135 +++++++++++++
 tb/tb_window_mac.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_mac_if.sv
// Handshake bundle between the window producer, the weight loader and window_mac.
// master drives windows/weights and consumes results; slave is the MAC datapath.
interface window_mac_if #(
  parameter int data_width  = 16,
  parameter int weight_size = 25,
  parameter int acc_width   = 40
);
  logic                                    w_load;
  logic signed [data_width-1:0]            w_in;
  logic                                    w_ready;
  logic                                    win_valid;
  logic [weight_size-1:0][data_width-1:0]  win;
  logic                                    ch_last;
  logic                                    win_ready;
  logic                                    res_valid;
  logic signed [acc_width-1:0]             res;
  logic                                    res_ready;

  modport master (
    output w_load, w_in, win_valid, win, ch_last, res_ready,
    input  w_ready, win_ready, res_valid, res
  );

  modport slave (
    input  w_load, w_in, win_valid, win, ch_last, res_ready,
    output w_ready, win_ready, res_valid, res
  );
endinterface

// File: rtl/window_mac.sv
// 5x5 window dot product against stationary weights, accumulated across channels.
// Three stages (multiply, row sums, accumulate) all frozen while a result is back-pressured.
module window_mac #(
  parameter int data_width  = 16,
  parameter int weight_size = 25,
  parameter int acc_width   = 40
) (
  input  logic         clk,
  input  logic         nrst,
  window_mac_if.slave  bus
);

  localparam int prod_w   = 2 * data_width;
  localparam int row_taps = 5;
  localparam int n_rows   = weight_size / row_taps;
  localparam int cnt_w    = $clog2(weight_size);

  logic signed [data_width-1:0] weight [weight_size];
  logic [cnt_w-1:0]             wcnt;
  logic                         w_ready_q;

  logic                         en;
  logic                         accept;

  logic                         s1_valid;
  logic                         s1_last;
  logic signed [prod_w-1:0]     prod [weight_size];

  logic                         s2_valid;
  logic                         s2_last;
  logic signed [acc_width-1:0]  part [n_rows];
  logic signed [acc_width-1:0]  part_next [n_rows];

  logic signed [acc_width-1:0]  acc;
  logic                         first;
  logic signed [acc_width-1:0]  s3_sum;
  logic signed [acc_width-1:0]  res_q;
  logic                         res_valid_q;

  // A result waiting on the consumer holds the whole pipe; weights keep loading.
  assign en            = ~(res_valid_q & ~bus.res_ready);
  assign bus.win_ready = w_ready_q & en & ~bus.w_load;
  assign accept        = bus.win_valid & bus.win_ready;

  assign bus.w_ready   = w_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res       = res_q;

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < weight_size; i++) weight[i] <= '0;
      wcnt      <= '0;
      w_ready_q <= 1'b0;
    end else if (bus.w_load) begin
      if (w_ready_q) begin
        // a load on a complete set always restarts at tap 0
        weight[0] <= bus.w_in;
        wcnt      <= cnt_w'(1);
        w_ready_q <= 1'b0;
      end else begin
        weight[wcnt] <= bus.w_in;
        if (wcnt == cnt_w'(weight_size - 1)) begin
          wcnt      <= '0;
          w_ready_q <= 1'b1;
        end else begin
          wcnt <= wcnt + cnt_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < weight_size; i++) prod[i] <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_last  <= accept & bus.ch_last;
      if (accept) begin
        for (int i = 0; i < weight_size; i++)
          prod[i] <= prod_w'($signed(bus.win[i])) * prod_w'(weight[i]);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < n_rows; r++) begin
      part_next[r] = '0;
      for (int c = 0; c < row_taps; c++)
        part_next[r] = part_next[r] + acc_width'(prod[r*row_taps + c]);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      for (int r = 0; r < n_rows; r++) part[r] <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      for (int r = 0; r < n_rows; r++) part[r] <= part_next[r];
    end
  end

  always_comb begin
    s3_sum = first ? '0 : acc;
    for (int r = 0; r < n_rows; r++) s3_sum = s3_sum + part[r];
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      acc         <= '0;
      first       <= 1'b1;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (en && s2_valid && s2_last) begin
        // a fresh result overrides any consume of the old one this cycle
        res_q       <= s3_sum;
        res_valid_q <= 1'b1;
        acc         <= '0;
        first       <= 1'b1;
      end else begin
        if (en && s2_valid) begin
          acc   <= s3_sum;
          first <= 1'b0;
        end
        if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_mac.sv
// Self-checking bench for window_mac: directed scenarios plus randomized windows
// and back-pressure, checked against a dot-product/accumulate reference model.
module tb_window_mac;

  typedef int win_t [25];

  logic clk;
  logic nrst;

  window_mac_if #(.data_width(16), .weight_size(25), .acc_width(40)) bus ();

  window_mac #(.data_width(16), .weight_size(25), .acc_width(40)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     w_m [25];
  longint acc_m = 0;
  longint exp_q [$];
  longint obs_q [$];
  logic   bp_en   = 1'b0;
  logic   rand_rdy = 1'b1;
  logic   rdy_drv  = 1'b1;

  assign bus.res_ready = bp_en ? rand_rdy : rdy_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) rand_rdy = ($urandom_range(0, 3) != 0);

  always begin
    @(negedge clk);
    #2;
    if (!nrst && bus.res_valid && bus.res_ready) obs_q.push_back(longint'(bus.res));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint sx40(input longint v);
    logic signed [39:0] t;
    t = v[39:0];
    return longint'(t);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic load_weights(input win_t vals);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.w_load = 1'b1;
      bus.w_in   = 16'(vals[i]);
      w_m[i]     = vals[i];
    end
    @(negedge clk);
    bus.w_load = 1'b0;
  endtask

  // Presents a window until it is taken; the model consumes it at the accepting edge.
  task automatic send_window(input win_t w, input bit last, output bit ok);
    longint dot;
    ok  = 1'b0;
    dot = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.win_valid = 1'b1;
      for (int i = 0; i < 25; i++) bus.win[i] = 16'(w[i]);
      bus.ch_last = last;
      #1;
      if (bus.win_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      for (int i = 0; i < 25; i++) dot += longint'(w[i]) * longint'(w_m[i]);
      acc_m += dot;
      if (last) begin
        exp_q.push_back(sx40(acc_m));
        acc_m = 0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.win_valid = 1'b0;
    bus.ch_last   = 1'b0;
  endtask

  task automatic wait_drain(output bit to);
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (obs_q.size() >= exp_q.size()) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    bus.w_load = 1'b0; bus.w_in = '0; bus.win_valid = 1'b0; bus.win = '0; bus.ch_last = 1'b0;
    repeat (3) @(negedge clk);
    bus.win_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.res !== 40'sd0 || bus.w_ready !== 1'b0 || bus.win_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: res_valid=%b res=%0d w_ready=%b win_ready=%b, required 0 0 0 0",
               bus.res_valid, bus.res, bus.w_ready, bus.win_ready);
    end
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.w_ready !== 1'b0 || bus.win_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL no_weights_no_accept: w_ready=%b win_ready=%b, required 0 0", bus.w_ready, bus.win_ready);
    end
    bus.win_valid = 1'b0;
  endtask

  task automatic test_basic();
    win_t w;
    bit ok, to;
    logic [2:0] rv;
    longint r3;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.w_load = 1'b1;
      bus.w_in   = 16'(i + 1);
      w_m[i]     = i + 1;
      if (i == 24) begin
        #1;
        n_checks++;
        if (bus.w_ready !== 1'b0 || bus.win_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL w_ready_before_last: w_ready=%b win_ready=%b, required 0 0", bus.w_ready, bus.win_ready);
        end
      end
    end
    @(negedge clk);
    bus.w_load = 1'b0;
    #1;
    n_checks++;
    if (bus.w_ready !== 1'b1 || bus.win_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL w_ready_after_load: w_ready=%b win_ready=%b, required 1 1", bus.w_ready, bus.win_ready);
    end
    foreach (w[i]) w[i] = 1;
    send_window(w, 1'b1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_accept: window not accepted within budget"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.win_valid = 1'b0;
      bus.ch_last   = 1'b0;
      #1;
      rv[k] = bus.res_valid;
      r3    = longint'(bus.res);
    end
    n_checks++;
    if (rv !== 3'b100 || r3 !== 325) begin
      n_fail++;
      $display("FAIL basic_latency: res_valid per cycle=%b res=%0d, required 100 and 325", rv, r3);
    end
    wait_drain(to);
    n_checks++;
    if (to || obs_q.size() != 1 || obs_q[0] !== 325) begin
      n_fail++;
      $display("FAIL basic_result: %0d results, first=%0d, required one result 325",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_multichannel();
    win_t wt, w;
    bit ok, to;
    int nok;
    foreach (wt[i]) wt[i] = -1;
    load_weights(wt);
    foreach (w[i]) w[i] = i;
    nok = 0;
    for (int c = 0; c < 3; c++) begin
      send_window(w, c == 2, ok);
      if (ok) nok++;
    end
    idle();
    wait_drain(to);
    n_checks++;
    if (to || nok != 3 || obs_q.size() != 1 || obs_q[0] !== -900) begin
      n_fail++;
      $display("FAIL multichannel: accepted=%0d results=%0d first=%0d, required 3 accepted, one result -900",
               nok, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    win_t wt, w [4];
    bit ok, to;
    foreach (wt[i]) wt[i] = rnd16();
    load_weights(wt);
    for (int k = 0; k < 4; k++) foreach (w[k][i]) w[k][i] = rnd16();
    rdy_drv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_window(w[k], 1'b1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_fill: window %0d not accepted", k); end
    end
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      bus.win_valid = 1'b1;
      for (int i = 0; i < 25; i++) bus.win[i] = 16'(w[3][i]);
      bus.ch_last = 1'b1;
      #1;
      n_checks++;
      if (bus.win_ready !== 1'b0 || bus.res_valid !== 1'b1 || longint'(bus.res) !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d win_ready=%b res_valid=%b res=%0d, required 0 1 %0d",
                 h, bus.win_ready, bus.res_valid, bus.res, exp_q[0]);
      end
    end
    @(negedge clk);
    bus.win_valid = 1'b0;
    rdy_drv = 1'b1;
    send_window(w[3], 1'b1, ok);
    idle();
    wait_drain(to);
    n_checks++;
    if (!ok || to || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: results=%0d, required 4", obs_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL stall_order: result %0d got %0d, required %0d", k, obs_q[k], exp_q[k]);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow_sign();
    win_t wt, w;
    bit ok, to;
    int nok;
    longint exp_c;
    foreach (wt[i]) wt[i] = 32767;
    load_weights(wt);
    foreach (w[i]) w[i] = 32767;
    nok = 0;
    for (int c = 0; c < 1000; c++) begin
      send_window(w, c == 999, ok);
      if (ok) nok++;
    end
    idle();
    // 25000 * 0x3FFF0001 exceeds 40 bits, so the accumulator wraps
    exp_c = sx40(longint'(25000) * longint'(32'h3FFF0001));
    wait_drain(to);
    n_checks++;
    if (to || nok != 1000 || obs_q.size() != 1 || obs_q[0] !== exp_c) begin
      n_fail++;
      $display("FAIL overflow_wrap: accepted=%0d results=%0d first=%0d, required 1000 accepted, one result %0d",
               nok, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0, exp_c);
    end
    obs_q.delete(); exp_q.delete();

    foreach (wt[i]) wt[i] = -32768;
    load_weights(wt);
    foreach (w[i]) w[i] = -32768;
    send_window(w, 1'b0, ok);
    send_window(w, 1'b1, ok);
    foreach (w[i]) w[i] = 32767;
    for (int c = 0; c < 3; c++) send_window(w, c == 2, ok);
    idle();
    wait_drain(to);
    n_checks++;
    if (to || obs_q.size() != 2 || obs_q[0] !== 64'sd53687091200 || obs_q[1] !== -64'sd80528179200) begin
      n_fail++;
      $display("FAIL sign_ext: results=%0d values %0d %0d, required 53687091200 -80528179200",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0, (obs_q.size() > 1) ? obs_q[1] : 0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reload();
    win_t wt, w;
    bit ok, to;
    int busy;
    foreach (wt[i]) wt[i] = 1;
    load_weights(wt);
    foreach (w[i]) w[i] = 1;
    send_window(w, 1'b1, ok);
    send_window(w, 1'b1, ok);
    busy = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.w_load = 1'b1;
      bus.w_in   = 16'sd2;
      w_m[i]     = 2;
      #1;
      if (bus.win_ready !== 1'b0) busy++;
    end
    n_checks++;
    if (busy != 0) begin
      n_fail++;
      $display("FAIL reload_win_ready: win_ready high in %0d load cycles, required 0", busy);
    end
    @(negedge clk);
    bus.w_load    = 1'b0;
    bus.win_valid = 1'b0;
    send_window(w, 1'b1, ok);
    idle();
    wait_drain(to);
    n_checks++;
    if (to || obs_q.size() != 3 || obs_q[0] !== 25 || obs_q[1] !== 25 || obs_q[2] !== 50) begin
      n_fail++;
      $display("FAIL reload_results: count=%0d values %0d %0d %0d, required 25 25 50", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 0, (obs_q.size() > 1) ? obs_q[1] : 0,
               (obs_q.size() > 2) ? obs_q[2] : 0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    win_t wt, w;
    bit ok, to;
    int leaks;
    foreach (wt[i]) wt[i] = 3;
    load_weights(wt);
    foreach (w[i]) w[i] = rnd16();
    send_window(w, 1'b0, ok);
    send_window(w, 1'b0, ok);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
    acc_m = 0;
    exp_q.delete(); obs_q.delete();
    foreach (w_m[i]) w_m[i] = 0;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.w_ready !== 1'b0 || bus.win_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: res_valid=%b w_ready=%b win_ready=%b, required 0 0 0",
               bus.res_valid, bus.w_ready, bus.win_ready);
    end
    leaks = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.win_ready !== 1'b0 || bus.res_valid !== 1'b0) leaks++;
    end
    n_checks++;
    if (leaks != 0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: win_ready/res_valid high in %0d cycles before reload, required 0", leaks);
    end
    bus.win_valid = 1'b0;
    load_weights(wt);
    foreach (w[i]) w[i] = rnd16();
    send_window(w, 1'b1, ok);
    idle();
    wait_drain(to);
    n_checks++;
    if (!ok || to || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL mid_reset_result: results=%0d first=%0d, required one result %0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0, exp_q[0]);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    win_t wt, w;
    bit ok, to, last;
    int nbad;
    foreach (wt[i]) wt[i] = rnd16();
    load_weights(wt);
    bp_en = 1'b1;
    nbad  = 0;
    for (int n = 0; n < 80; n++) begin
      foreach (w[i]) w[i] = rnd16();
      last = (n == 79) || ($urandom_range(0, 2) == 0);
      send_window(w, last, ok);
      if (!ok) nbad++;
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    bp_en   = 1'b0;
    rdy_drv = 1'b1;
    wait_drain(to);
    n_checks++;
    if (nbad != 0 || to || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: results=%0d, required %0d (unaccepted=%0d)", obs_q.size(), exp_q.size(), nbad);
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random_result: result %0d got %0d, required %0d", k, obs_q[k], exp_q[k]);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multichannel();
    test_stall();
    test_overflow_sign();
    test_reload();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
